// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file.
// Optional feature macro (used by regfile_mp): REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int NR_MAX = 4;
  localparam int NW_MAX = 2;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Initialisation sequencer: walks ptr over every entry after reset or clr,
// emitting a zero-write strobe, and reports busy until the walk completes.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int M  = 32,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(M - 1)) state_d = RUN;
        if (clr) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == INIT);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered read ports.
// Define REGFILE_BYPASS_EN for write-to-read forwarding; otherwise read-before-write.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int N  = 32,
  parameter int M  = 32,
  parameter int NR = 2,
  parameter int NW = 1,
  parameter int AW = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic             busy,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*N-1:0]  wd,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*N-1:0]  q
);

  if (NR < 1 || NR > NR_MAX || NW < 1 || NW > NW_MAX || M < 2 || (M & (M - 1)) != 0)
  begin : g_bad_cfg
    $error("regfile_mp: unsupported NR/NW/M configuration");
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [NW-1:0] wr_en;
  logic [N-1:0]  mem    [M];
  logic [N-1:0]  rd_val [NR];

  regfile_init_ctrl #(.M(M), .AW(AW)) u_init_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writeback is locked out for the whole clearing walk.
  assign wr_en = we & {NW{~busy}};

  // NOTE: the array has no reset; the sequencer zeroes it, which keeps the
  // storage mappable to plain flops/RAM without a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      // Ascending order: the highest-index port's write lands last and wins.
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k]) mem[wa[k*AW +: AW]] <= wd[k*N +: N];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_val[i] = mem[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k] && (wa[k*AW +: AW] == ra[i*AW +: AW])) rd_val[i] = wd[k*N +: N];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (re[i]) q[i*N +: N] <= busy ? '0 : rd_val[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (M=32, N=32, NR=2, NW=2) with a read scoreboard.
module tb_regfile_mp;

  localparam int N  = 32;
  localparam int M  = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic             busy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*N-1:0]  wd;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] ra;
  logic [NR*N-1:0]  q;

  regfile_mp #(.N(N), .M(M), .NR(NR), .NW(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .busy  (busy),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .re    (re),
    .ra    (ra),
    .q     (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [M];
  logic [31:0] q_model   [NR];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int p, input int a, input logic [31:0] exp, input string tag);
    logic [31:0] av;
    av = a;
    re[p] = 1'b1;
    ra[p*AW +: AW] = av[AW-1:0];
    q_model[p] = exp;
    sb.push_back('{tag, p, exp});
  endtask

  task automatic hold(input int p, input string tag);
    sb.push_back('{tag, p, q_model[p]});
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d);
    logic [31:0] av;
    av = a;
    we[k] = 1'b1;
    wa[k*AW +: AW] = av[AW-1:0];
    wd[k*N +: N] = d;
    mem_model[a] = d;
  endtask

  // One clock: compare everything queued for this edge, then idle the inputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, q[e.port*N +: N], e.val);
    end
    re  = '0;
    we  = '0;
    clr = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(M));
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < M; a += 2) begin
      rd(0, a, 32'h0, tag);
      rd(1, a + 1, 32'h0, tag);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_v;
    reset = 1'b0;
    clr = 1'b0;
    we = '0;
    wa = '0;
    wd = '0;
    re = '0;
    ra = '0;
    for (int i = 0; i < M; i++) mem_model[i] = 32'h0;
    for (int i = 0; i < NR; i++) q_model[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_q", q[31:0], 32'h0);
    check("reset_q1", q[63:32], 32'h0);
    check("reset_busy", 32'(busy), 32'h1);

    reset = 1'b1;
    count_busy("init_busy_cycles");
    read_all_zero("init_zero");

    // Single write then dual-port read of the same entry, then hold.
    wr(0, 5, 32'hDEADBEEF);
    tick();
    rd(0, 5, 32'hDEADBEEF, "rd5_p0");
    rd(1, 5, 32'hDEADBEEF, "rd5_p1");
    tick();
    hold(0, "hold_p0");
    hold(1, "hold_p1");
    tick();

    // Both ports hit address 7: port 1 wins.
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    tick();
    rd(0, 7, 32'h22, "wprio_rd7");
    tick();

    // Boundary addresses 0 and M-1.
    wr(0, 0, 32'h0BAD_0000);
    wr(1, M - 1, 32'hCAFE_F00D);
    tick();
    rd(0, M - 1, 32'hCAFE_F00D, "rd_top");
    rd(1, 0, 32'h0BAD_0000, "rd_bottom");
    tick();

    // Same-cycle write and read of address 3.
    wr(0, 3, 32'h5A);
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hA5;
`else
    exp_v = 32'h5A;
`endif
    rd(1, 3, exp_v, "rw_same_cycle");
    wr(0, 3, 32'hA5);
    tick();
    rd(0, 3, 32'hA5, "rd3_after");
    tick();

    // clr with a write attempt and reads while busy.
    clr = 1'b1;
    tick();
    check("clr_busy", 32'(busy), 32'h1);
    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        if (n < 3) begin
          we[0] = 1'b1;
          wa[AW-1:0] = 5'd1;
          wd[N-1:0] = 32'hFF;
          rd(0, 5, 32'h0, "busy_rd_zero");
          hold(1, "busy_hold_p1");
        end
        tick();
        n++;
      end
      check("clr_busy_cycles", 32'(n), 32'(M));
    end
    for (int i = 0; i < M; i++) mem_model[i] = 32'h0;
    read_all_zero("clr_zero");

    // Asynchronous reset part-way through a clear walk.
    wr(0, 9, 32'h1234);
    tick();
    rd(0, 9, 32'h1234, "rd9_p0");
    rd(1, 9, 32'h1234, "rd9_p1");
    tick();
    clr = 1'b1;
    tick();
    repeat (10) tick();
    hold(0, "hold_in_init");
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_q0", q[31:0], 32'h0);
    check("async_q1", q[63:32], 32'h0);
    check("async_busy", 32'(busy), 32'h1);
    q_model[0] = 32'h0;
    q_model[1] = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy("rerun_busy_cycles");
    for (int i = 0; i < M; i++) mem_model[i] = 32'h0;
    rd(0, 9, 32'h0, "rd9_after_reset");
    rd(1, 10, 32'h0, "rd10_after_reset");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
